alu_iterative: RTL
==================

# alu_iterative

Parametrised, registered successor to the processor's combinational ALU. It adds a start/ready/done handshake, explicit shift-amount masking, AND/XOR/SLTU, and multi-cycle shift-add multiply plus restoring divide. It sits in the execute stage. The control unit stalls the pipeline while `ready` is low.

## Interface
- `WIDTH`, default 32: operand and result width. Must be a power of two and at least 8.
- `SHAMT_W`, default `$clog2(WIDTH)`: number of low `inputB` bits used as the shift amount. Derived; do not override.
- `clock`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request. Accepted when `start && ready` at a rising edge.
- `control`  in  4  opcode, sampled at accept.
- `inputA`, `inputB`  in  WIDTH  operands, sampled at accept. They need not be held afterwards.
- `ready`  out  1  high when a new request can be accepted.
- `done`  out  1  one-cycle pulse; `out` and `illegal` are valid in that cycle.
- `out`  out  WIDTH  result register. Holds its value until the next `done`.
- `illegal`  out  1  set with `done` when the opcode was unsupported.

## Operation
- Opcodes:
  - 0000 add; 0001 sll; 0010 slt (signed); 0011 sub.
  - 0100 sra; 0101 srl; 0110 or; 0111 and; 1000 xor.
  - 1001 sltu; 1010 mul (low WIDTH bits of the product); 1011 mulhu (high WIDTH bits of the unsigned product).
  - 1100 divu; 1101 remu.
  - 1110 and 1111 are illegal.
- Shift amount for sll/srl/sra is `inputB[SHAMT_W-1:0]`. Upper bits are ignored.
- slt/sltu return zero-extended 1 or 0.
- add/sub wrap modulo 2^WIDTH. No flags.
- FSM states:
  - IDLE: `ready`=1.
  - MUL: shift-add, one bit per cycle, 2*WIDTH-bit accumulator.
  - DIV: restoring divide, one quotient bit per cycle.
- Transitions:
  - IDLE with an accepted fast opcode (0000–1001, illegal, or any div opcode when not compiled in): stays in IDLE. Result is registered.
  - IDLE with accepted mul/mulhu: goes to MUL.
  - IDLE with accepted divu/remu: goes to DIV.
  - MUL or DIV: a WIDTH-cycle iteration counter runs. On the last iteration, `out` is loaded and the FSM returns to IDLE.
- Divide by zero:
  - divu returns all ones.
  - remu returns `inputA`.
  - Both still take the full WIDTH iterations and raise no illegal flag.
- Illegal opcode: `out`=0, `illegal`=1. Handled as a fast op.
- `start` while `ready`=0 is ignored. There is no queuing and no error.
- Reset in any state returns to IDLE immediately.
  - `ready`=1, `done`=0, `out`=0, `illegal`=0, iteration counter=0.
  - An in-flight operation is discarded and produces no `done`.
- Reset values of outputs: `ready` 1, `done` 0, `out` 0, `illegal` 0.

## Timing
- Cycle 0 is the cycle in which `start && ready` is sampled.
- Fast ops:
  - `done`=1 in cycle 1 with the result.
  - `ready` stays 1, so back-to-back accepts are allowed every cycle.
  - Latency is 1.
- mul/mulhu/divu/remu:
  - `ready`=0 in cycles 1..WIDTH.
  - `done`=1 and `ready`=1 in cycle WIDTH+1.
  - A new `start` may be accepted in cycle WIDTH+1 itself.
- `done` is never high for two consecutive cycles from a single request.
- `illegal` is only meaningful while `done`=1. It is cleared on the next accept.

## Configuration
- `ALU_ITERATIVE_DIV_EN` defined:
  - DIV state, divider datapath and opcodes 1100/1101 are compiled in, as described above.
- `ALU_ITERATIVE_DIV_EN` undefined:
  - DIV state and datapath are absent.
  - 1100 and 1101 are treated as illegal fast ops: `out`=0, `illegal`=1, `done` in cycle 1.
  - Multiply is unaffected.

## Test plan
- Reset, then idle: `ready`=1, `done`=0, `out`=0. Apply `start`=1 with `control`=0000, A=5, B=7 → cycle 1: `done`=1, `out`=12. Then 0011 with A=3, B=5 → `out`=0xFFFFFFFE.
- Shift masking, WIDTH=32: sll with A=1, B=0x21 → `out`=2. sra with A=0x80000000, B=4 → 0xF8000000. srl with the same operands → 0x08000000.
- mul with A=0xFFFFFFFF, B=2:
  - Cycles 1..32: `ready`=0.
  - Cycle 33: `done`=1, `out`=0xFFFFFFFE.
  - mulhu with the same operands → `out`=1.
  - A `start` pulse during cycles 1..32 is ignored.
- With the macro defined:
  - divu 100/7 → 14; remu 100/7 → 2.
  - divu 9/0 → 0xFFFFFFFF; remu 9/0 → 9.
  - All return `done` in cycle 33.
- With the macro undefined: divu → cycle 1 `done`=1, `illegal`=1, `out`=0. Opcode 1111 gives the same response in both builds.
- Assert `reset` in cycle 10 of a mul → next cycle `ready`=1, `out`=0, and no `done` ever arrives for that request. Then slt with A=0xFFFFFFFF, B=1 → `out`=1, and sltu with the same operands → 0.

Source files
------------

// File: rtl/alu_iterative.sv
// alu_iterative
//   Registered execute-stage ALU with a start/ready/done handshake. Simple
//   operations complete in one cycle. Multiply uses shift-add and divide uses
//   restoring division. Each of these iterates one bit per cycle for WIDTH
//   cycles.
//
//   Optional feature macro: ALU_ITERATIVE_DIV_EN
//     When it is defined, the DIV state, the divider datapath and opcodes
//     1100 (divu) / 1101 (remu) are built.
//     When it is undefined, those opcodes are answered as illegal fast ops.
//
//   Ports
//     clock    rising-edge clock for all state
//     reset    synchronous, active-high reset
//     start    request, accepted when start && ready at a rising edge
//     control  4-bit opcode, sampled at accept
//     inputA   operand A, sampled at accept
//     inputB   operand B, sampled at accept (low SHAMT_W bits = shift amount)
//     ready    high when a new request can be accepted
//     done     one-cycle pulse; out/illegal valid in that cycle
//     out      result register, held until the next done
//     illegal  set with done when the opcode was unsupported
module alu_iterative #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             illegal
);

`ifdef ALU_ITERATIVE_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL} state_t;
`endif

    state_t               state;
    logic [SHAMT_W-1:0]   count;
    logic                 upper;
    logic [SHAMT_W-1:0]   shamt;
    logic [WIDTH-1:0]     fastres;
    logic                 fastill;
    logic                 ismul;
    logic                 lastiter;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH:0]       mulsum;
    logic [2*WIDTH-1:0]   accnext;
`ifdef ALU_ITERATIVE_DIV_EN
    logic                 isdiv;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     remnext;
    logic [WIDTH-1:0]     quotnext;
`endif

    assign shamt    = inputB[SHAMT_W-1:0];
    assign ismul    = (control[3:1] == 3'b101);
    assign lastiter = (count == SHAMT_W'(WIDTH - 1));
`ifdef ALU_ITERATIVE_DIV_EN
    assign isdiv    = (control[3:1] == 3'b110);
`endif

    // Single-cycle results, computed straight from the request inputs.
    // Anything not listed here falls to the default branch and is flagged
    // illegal. The multi-cycle opcodes also land there, but the FSM routes
    // them to their own states before this result is ever used.
    always_comb begin
        fastres = '0;
        fastill = 1'b0;
        case (control)
            4'b0000: fastres = inputA + inputB;
            4'b0001: fastres = inputA << shamt;
            4'b0010: fastres = {{(WIDTH-1){1'b0}}, ($signed(inputA) < $signed(inputB))};
            4'b0011: fastres = inputA - inputB;
            4'b0100: fastres = $signed(inputA) >>> shamt;
            4'b0101: fastres = inputA >> shamt;
            4'b0110: fastres = inputA | inputB;
            4'b0111: fastres = inputA & inputB;
            4'b1000: fastres = inputA ^ inputB;
            4'b1001: fastres = {{(WIDTH-1){1'b0}}, (inputA < inputB)};
            default: fastill = 1'b1;
        endcase
    end

    // Shift-add multiply step. The low half of the accumulator starts out
    // holding the multiplier and is consumed from bit 0 upward. Each step
    // conditionally adds the multiplicand into the high half, then shifts the
    // whole accumulator right one place, keeping the carry. After WIDTH steps
    // the accumulator holds the full 2*WIDTH-bit product.
    always_comb begin
        mulsum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        accnext = {mulsum, acc[WIDTH-1:1]};
    end

`ifdef ALU_ITERATIVE_DIV_EN
    // Restoring divide step. The next dividend bit is shifted into the
    // partial remainder, and a trial subtraction of the divisor is made. A
    // clear sign bit means the subtraction fits: keep it and record a 1
    // quotient bit. With a zero divisor every trial fits, so the quotient
    // comes out all ones and the remainder ends up equal to the dividend.
    always_comb begin
        shifted  = {rem, quot[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        remnext  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quotnext = {quot[WIDTH-2:0], ~trial[WIDTH]};
    end
`endif

    // Control FSM and all output registers. In IDLE a fast op is answered
    // on the next cycle without leaving IDLE. Multiply and divide drop ready
    // and step once per cycle. The last step loads out, pulses done and
    // raises ready together, so a new request can be taken in that same
    // cycle. The 'upper' flag picks mulhu over mul, or remu over divu.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            out     <= '0;
            illegal <= 1'b0;
            count   <= '0;
            upper   <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
`ifdef ALU_ITERATIVE_DIV_EN
            quot    <= '0;
            rem     <= '0;
            divisor <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    ready <= 1'b1;
                    if (start) begin
                        if (ismul) begin
                            state   <= MUL;
                            ready   <= 1'b0;
                            illegal <= 1'b0;
                            count   <= '0;
                            upper   <= control[0];
                            acc     <= {{WIDTH{1'b0}}, inputB};
                            mcand   <= inputA;
`ifdef ALU_ITERATIVE_DIV_EN
                        end else if (isdiv) begin
                            state   <= DIV;
                            ready   <= 1'b0;
                            illegal <= 1'b0;
                            count   <= '0;
                            upper   <= control[0];
                            quot    <= inputA;
                            rem     <= '0;
                            divisor <= inputB;
`endif
                        end else begin
                            out     <= fastres;
                            illegal <= fastill;
                            done    <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc   <= accnext;
                    count <= count + SHAMT_W'(1);
                    if (lastiter) begin
                        out   <= upper ? accnext[2*WIDTH-1:WIDTH] : accnext[WIDTH-1:0];
                        done  <= 1'b1;
                        ready <= 1'b1;
                        count <= '0;
                        state <= IDLE;
                    end
                end
`ifdef ALU_ITERATIVE_DIV_EN
                DIV: begin
                    rem   <= remnext;
                    quot  <= quotnext;
                    count <= count + SHAMT_W'(1);
                    if (lastiter) begin
                        out   <= upper ? remnext : quotnext;
                        done  <= 1'b1;
                        ready <= 1'b1;
                        count <= '0;
                        state <= IDLE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
